// File: rtl/read_burst_issue.sv
// Avalon-MM read command issuer: splits a byte transfer into bursts, throttled by
// downstream FIFO space against outstanding reads, and signals done once all data returns.
module read_burst_issue #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int LENGTH_WIDTH      = 32,
  parameter int BURST_COUNT_WIDTH = 3,
  parameter int WORD_SIZE_LOG2    = 2,
  parameter int PENDING_WIDTH     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         go,
  input  logic [ADDRESS_WIDTH-1:0]     start_address,
  input  logic [LENGTH_WIDTH-1:0]      transfer_length,
  input  logic [BURST_COUNT_WIDTH-1:0] burst_count,
  input  logic [PENDING_WIDTH-1:0]     fifo_space,
  input  logic                         master_waitrequest,
  input  logic                         master_readdatavalid,
  output logic [ADDRESS_WIDTH-1:0]     current_address,
  output logic [LENGTH_WIDTH-1:0]      current_length,
  output logic [ADDRESS_WIDTH-1:0]     master_address,
  output logic                         master_read,
  output logic [BURST_COUNT_WIDTH-1:0] master_burstcount,
  output logic                         busy,
  output logic                         done
);

  localparam int PW1 = PENDING_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_REQ, S_DRAIN} state_t;

  state_t                       state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]     cur_addr_q, cur_addr_d;
  logic [LENGTH_WIDTH-1:0]      cur_len_q, cur_len_d;
  logic [ADDRESS_WIDTH-1:0]     m_addr_q, m_addr_d;
  logic                         m_read_q, m_read_d;
  logic [BURST_COUNT_WIDTH-1:0] m_bc_q, m_bc_d;
  logic [PENDING_WIDTH-1:0]     pend_q, pend_d;
  logic                         done_q, done_d;

  logic [PW1-1:0]               need;
  logic                         can_issue;
  logic                         accept;
  logic                         pend_dec;
  logic [PENDING_WIDTH-1:0]     pend_inc;
  logic [ADDRESS_WIDTH-1:0]     addr_step;
  logic [LENGTH_WIDTH-1:0]      len_step;
  logic [LENGTH_WIDTH-1:0]      len_after;

  // Space check is one bit wider than the counter so pending+burst cannot wrap.
  assign need      = {1'b0, pend_q} + PW1'(burst_count);
  assign can_issue = (burst_count != '0) && (need <= {1'b0, fifo_space});
  assign accept    = (state_q == S_REQ) && !master_waitrequest;
  assign addr_step = ADDRESS_WIDTH'(m_bc_q) << WORD_SIZE_LOG2;
  assign len_step  = LENGTH_WIDTH'(m_bc_q) << WORD_SIZE_LOG2;
  assign len_after = (cur_len_q > len_step) ? (cur_len_q - len_step) : '0;
  assign pend_inc  = accept ? PENDING_WIDTH'(m_bc_q) : '0;
  assign pend_dec  = master_readdatavalid && (pend_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      cur_len_q  <= '0;
      m_addr_q   <= '0;
      m_read_q   <= 1'b0;
      m_bc_q     <= '0;
      pend_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cur_len_q  <= cur_len_d;
      m_addr_q   <= m_addr_d;
      m_read_q   <= m_read_d;
      m_bc_q     <= m_bc_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go && (transfer_length != '0)) state_d = S_ARM;
      S_ARM:   if (can_issue) state_d = S_REQ;
      S_REQ:   if (!master_waitrequest) state_d = (len_after == '0) ? S_DRAIN : S_ARM;
      S_DRAIN: if (pend_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cur_addr_d = cur_addr_q;
    cur_len_d  = cur_len_q;
    m_addr_d   = m_addr_q;
    m_read_d   = m_read_q;
    m_bc_d     = m_bc_q;
    done_d     = 1'b0;
    pend_d     = pend_q + pend_inc - PENDING_WIDTH'(pend_dec);
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          cur_addr_d = start_address;
          cur_len_d  = transfer_length;
          done_d     = (transfer_length == '0);
        end
      end
      S_ARM: begin
        if (can_issue) begin
          m_read_d = 1'b1;
          m_addr_d = current_address;
          m_bc_d   = burst_count;
        end
      end
      S_REQ: begin
        if (accept) begin
          m_read_d   = 1'b0;
          cur_addr_d = cur_addr_q + addr_step;
          cur_len_d  = len_after;
        end
      end
      S_DRAIN: done_d = (pend_q == '0);
      default: ;
    endcase
  end

  assign current_address   = cur_addr_q;
  assign current_length    = cur_len_q;
  assign master_address    = m_addr_q;
  assign master_read       = m_read_q;
  assign master_burstcount = m_bc_q;
  assign busy              = (state_q != S_IDLE);
  assign done              = done_q;

endmodule
